hybrid_pwm_sd_multi: RTL

//  N-channel hybrid PWM / sigma-delta audio DAC. Shared free-running PWM counter; per-channel

---
 rtl/hpsd_pkg.sv | 28 ++
 rtl/hpsd_ramp_ctrl.sv | 84 ++++++++
 rtl/hybrid_pwm_sd_multi.sv | 118 +++++++++++
 3 files changed

// File: rtl/hpsd_pkg.sv
// Hybrid PWM / sigma-delta DAC shared types.
// Ramp state encoding and derived width helpers.
package hpsd_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_TERM,
    ST_HALT
  } ramp_state_t;

  function automatic int pmax(input int pwm_bits);
    return (1 << pwm_bits) - 1;
  endfunction

  function automatic int maxth(input int pwm_bits);
    return pmax(pwm_bits) - 1;
  endfunction

  function automatic int frac_bits(input int dw, input int pwm_bits);
    return dw - pwm_bits;
  endfunction

  function automatic int mid(input int ramp_bits);
    return 1 << (ramp_bits - 1);
  endfunction

endpackage

// File: rtl/hpsd_ramp_ctrl.sv
// Anti-pop ramp sequencer and accumulator dump timer.
// Ramp moves one step per dump tick; RUN->TERM on terminate.
module hpsd_ramp_ctrl
  import hpsd_pkg::*;
#(
  parameter int DUMP_BITS  = 8,
  parameter int RAMP_BITS  = 14,
  parameter int RAMP_START = 'h3E00
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 terminate,
  input  logic                 period_end,
  output ramp_state_t          state,
  output logic [RAMP_BITS-1:0] ramp,
  output logic                 tick
);

  localparam logic [RAMP_BITS-1:0] RMID =
    RAMP_BITS'(mid(RAMP_BITS));
  localparam logic [RAMP_BITS-1:0] RMAX = '1;
  localparam logic [RAMP_BITS-1:0] RINIT =
    RAMP_BITS'(RAMP_START);

  logic [DUMP_BITS-1:0] dumpctr;
  ramp_state_t          state_nx;
  logic [RAMP_BITS-1:0] ramp_nx;
  logic [RAMP_BITS-1:0] ramp_dn;
  logic [RAMP_BITS-1:0] ramp_up;

  assign tick    = period_end && (dumpctr == '0);
  assign ramp_dn = ramp - 1'b1;
  assign ramp_up = ramp + 1'b1;

  // Count PWM periods; tick fires as the count wraps
  always_ff @(posedge clk) begin
    if (!reset_n)
      dumpctr <= '0;
    else if (period_end)
      dumpctr <= dumpctr + 1'b1;
  end

  // Ramp state and value registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_INIT;
      ramp  <= RINIT;
    end else begin
      state <= state_nx;
      ramp  <= ramp_nx;
    end
  end

  // Ramp sequencing: down to mid at power-on, up to max on terminate
  always_comb begin
    state_nx = state;
    ramp_nx  = ramp;
    unique case (state)
      ST_INIT: begin
        if (tick) begin
          ramp_nx = ramp_dn;
          if (ramp_dn == RMID)
            state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (terminate) begin
          state_nx = ST_TERM;
          ramp_nx  = RMID;
        end
      end
      ST_TERM: begin
        if (tick) begin
          ramp_nx = ramp_up;
          if (ramp_up == RMAX)
            state_nx = ST_HALT;
        end
      end
      ST_HALT: ramp_nx = RMAX;
      default: state_nx = ST_INIT;
    endcase
  end

endmodule

// File: rtl/hybrid_pwm_sd_multi.sv
// N-channel hybrid PWM / sigma-delta audio DAC.
// One channel's threshold is recomputed per PWM period.
module hybrid_pwm_sd_multi
  import hpsd_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int DW         = 16,
  parameter int PWM_BITS   = 5,
  parameter int DUMP_BITS  = 8,
  parameter int RAMP_BITS  = 14,
  parameter int RAMP_START = 'h3E00
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   terminate,
  input  logic [CHANNELS*DW-1:0] d,
  output logic [CHANNELS-1:0]    q,
  output logic                   init_done,
  output logic                   term_done
);

  localparam int F  = frac_bits(DW, PWM_BITS);
  localparam int PW = DW + PWM_BITS + 1;
  localparam int CW =
    (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [PWM_BITS-1:0] PMAX =
    PWM_BITS'(pmax(PWM_BITS));
  localparam logic [PWM_BITS-1:0] MAXTH =
    PWM_BITS'(maxth(PWM_BITS));
  localparam logic [F-1:0] HALF = F'(1 << (F - 1));

  logic [PWM_BITS-1:0] pwmctr;
  logic [CW-1:0]       ch;
  logic [PWM_BITS-1:0] thr  [CHANNELS];
  logic [F-1:0]        frac [CHANNELS];
  logic [DW-1:0]       d_arr [CHANNELS];
  logic                period_end;
  logic                tick;
  ramp_state_t         state;
  logic [RAMP_BITS-1:0] ramp;
  logic [DW-1:0]       x;
  logic [PW-1:0]       prod;
  logic [DW-1:0]       inc;
  logic [DW-1:0]       s;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_d
    assign d_arr[k] = d[k*DW +: DW];
  end

  assign period_end = (pwmctr == PMAX);
  assign init_done  = (state != ST_INIT);
  assign term_done  = (state == ST_HALT);

  hpsd_ramp_ctrl #(
    .DUMP_BITS  (DUMP_BITS),
    .RAMP_BITS  (RAMP_BITS),
    .RAMP_START (RAMP_START)
  ) u_ramp (
    .clk        (clk),
    .reset_n    (reset_n),
    .terminate  (terminate),
    .period_end (period_end),
    .state      (state),
    .ramp       (ramp),
    .tick       (tick)
  );

  // Shared scaler: sample or ramp code into threshold units
  always_comb begin
    x = (state == ST_RUN) ? d_arr[ch]
      : (DW'(ramp) << (DW - RAMP_BITS));
    prod = PW'(x) * PW'(MAXTH) + (PW'(1) << DW);
    inc  = DW'(prod >> PWM_BITS);
    s    = inc + DW'(frac[ch]);
  end

  // Free-running PWM counter and round-robin channel pointer
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pwmctr <= PMAX;
      ch     <= '0;
    end else begin
      pwmctr <= pwmctr + 1'b1;
      if (period_end) begin
        if (ch == CW'(CHANNELS - 1))
          ch <= '0;
        else
          ch <= ch + 1'b1;
      end
    end
  end

  // Per-channel output flop, threshold and fraction accumulator
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        q[k]    <= 1'b0;
        thr[k]  <= MAXTH;
        frac[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (period_end)
          q[k] <= 1'b1;
        else if (pwmctr == thr[k])
          q[k] <= 1'b0;
        if (tick)
          frac[k] <= HALF;
        if (period_end && (CW'(k) == ch)) begin
          thr[k] <= s[DW-1:F];
          if (!tick)
            frac[k] <= s[F-1:0];
        end
      end
    end
  end

endmodule
